uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer and launch controller directly upstream of the UART TX block.
//  Host writes bytes at any rate; block stores them in a circular FIFO and feeds
//  the transmitter one byte at a time: one-cycle start pulse, then waits for its done tick.
//  Decouples bursty host writes from the 16x-oversampled serial rate.
// PARAMETERS
//  DATA_W      8   byte width; must match the transmitter data width
//  DEPTH_LOG2  4   log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries)
// PORTS
//  clk           in   1                 system clock
//  reset_n       in   1                 reset, active-low, synchronous
//  iWr           in   1                 host write strobe, one byte per cycle
//  iWr_data      in   DATA_W            host write byte
//  oFull         out  1                 count == DEPTH
//  oEmpty        out  1                 count == 0
//  oCount        out  DEPTH_LOG2+1      bytes stored, 0..DEPTH
//  oTx_start     out  1                 one-cycle launch pulse to transmitter
//  oTx_data      out  DATA_W            byte to transmitter, valid while oTx_start=1
//  iTx_done_tick in   1                 transmitter stop-bit-complete pulse
//  oBusy         out  1                 launcher not in IDLE
//  oErr          out  1                 sticky overflow (see CONFIGURATION)
//  iClr_err      in   1                 clears oErr
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low.
//  Reset (reset_n=0 at edge): rd/wr pointers=0, oCount=0, oEmpty=1, oFull=0,
//   oTx_start=0, oTx_data=0, oBusy=0, oErr=0, state=IDLE. Transmitter shares reset;
//   reset mid-frame drops queued bytes and the launch in flight, no pulse replayed.
//  Write: accepted at edge when iWr=1 and oFull=0 (full evaluated pre-edge);
//   iWr while full is dropped, storage and count unchanged.
//  Pointers DEPTH_LOG2 bits, wrap modulo DEPTH; count tracks separately, no pointer-compare ambiguity.
//  Launcher FSM, registered outputs:
//   IDLE   : oEmpty=0 -> LAUNCH; at same edge oTx_data<=head, oTx_start<=1, pop head.
//   LAUNCH : oTx_start=1 for exactly one cycle -> BUSY; oTx_start<=0.
//   BUSY   : iTx_done_tick=1 -> IDLE; oTx_data held at last byte.
//  oBusy=1 in LAUNCH and BUSY. iTx_done_tick outside BUSY is ignored.
//  Latency: write accepted at edge N into empty FIFO in IDLE -> oTx_start high
//   in the cycle after edge N+1. Back-to-back: done tick at edge M -> next
//   oTx_start high after edge M+1 (transmitter is idle by then).
//  Simultaneous write+pop: count unchanged, both take effect; if full pre-edge,
//   write dropped even though a pop frees a slot that cycle.
//  oCount/oFull/oEmpty update at the same edge as the write/pop.
// CONFIGURATION
//  UART_TX_FIFO_OVF_EN defined: oErr set at edge where iWr=1 and oFull=1;
//   stays 1 until iClr_err=1 or reset; set wins over simultaneous clear.
//  Not defined: oErr tied 0, iClr_err unused, no overflow register.
// STRUCTURE
//  Shared header uart_pkg: launcher state encodings (IDLE/LAUNCH/BUSY),
//   default DATA_W, oversample constant 16 shared with TX/RX blocks.
//  One sub-module: sync_fifo_mem (register array, wr/rd pointers, count, full/empty).
//  Top: launcher FSM, output registers, optional overflow flag.
// TESTING
//  Reset: hold reset_n=0 2 cycles -> oEmpty=1, oCount=0, oTx_start=0, oErr=0.
//  Single byte: write 0xA5 into empty -> oTx_start 1 cycle, oTx_data=0xA5,
//   oCount 1->0; no further pulse until iTx_done_tick.
//  Burst: write 0x01..0x10 (16) -> oFull=1; pulse done ticks -> bytes
//   launched in order 0x01..0x10, exactly one start per done tick.
//  Overflow: fill 16, write 0xEE -> dropped, oCount=16, oErr=1 (0 if macro
//   undefined); iClr_err -> oErr=0; 0xEE never appears on oTx_data.
//  Wrap/simultaneous: keep count at 8 with write+launch same cycle for 40
//   bytes -> oCount stable, data order preserved across pointer wrap.
//  Mid-op reset: reset in BUSY with 5 queued -> all flags reset values, no start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: launcher state encoding, default widths and the
// 16x oversample constant used by the TX/RX blocks.
package uart_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int OVERSAMPLE     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } launch_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Circular byte store with wr/rd pointers and a separate occupancy count,
// so full and empty never depend on comparing wrapped pointers.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_wr;
    logic                  w_rd;

    // Full is judged on the pre-edge count: a pop in the same cycle does not
    // open a slot for a simultaneous write.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side byte FIFO plus launcher that hands one byte at a time to the UART TX.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  iWr,
    input  logic [DATA_W-1:0]     iWr_data,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic [DEPTH_LOG2:0]   oCount,
    output logic                  oTx_start,
    output logic [DATA_W-1:0]     oTx_data,
    input  logic                  iTx_done_tick,
    output logic                  oBusy,
    output logic                  oErr,
    input  logic                  iClr_err,
    output launch_state_t         oDbg_state
);

    launch_state_t     r_state;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_busy;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;

    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    sync_fifo_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (iWr),
        .i_wr_data (iWr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (oCount),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Handshake to the transmitter: oTx_start is a single-cycle pulse with
    // oTx_data valid alongside; no new pulse until iTx_done_tick is seen in BUSY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= ST_LAUNCH;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_head;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    r_state    <= ST_BUSY;
                    r_tx_start <= 1'b0;
                end
                ST_BUSY: begin
                    if (iTx_done_tick) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_err;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_err <= 1'b0;
        else if (iWr && w_full)
            r_err <= 1'b1;
        else if (iClr_err)
            r_err <= 1'b0;
    end

    assign oErr = r_err;
`else
    logic w_unused_clr_err;
    assign w_unused_clr_err = iClr_err;
    assign oErr             = 1'b0;
`endif

    assign oFull      = w_full;
    assign oEmpty     = w_empty;
    assign oTx_start  = r_tx_start;
    assign oTx_data   = r_tx_data;
    assign oBusy      = r_busy;
    assign oDbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scenario tasks plus a launch monitor checking bytes
// against a queue of accepted writes.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          iWr = 1'b0;
    logic [7:0]    iWr_data = 8'h00;
    logic          oFull;
    logic          oEmpty;
    logic [4:0]    oCount;
    logic          oTx_start;
    logic [7:0]    oTx_data;
    logic          iTx_done_tick = 1'b0;
    logic          oBusy;
    logic          oErr;
    logic          iClr_err = 1'b0;
    launch_state_t dbg_state;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_starts = 0;
    logic       prev_start = 1'b0;

`ifdef UART_TX_FIFO_OVF_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    uart_tx_fifo dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iWr           (iWr),
        .iWr_data      (iWr_data),
        .oFull         (oFull),
        .oEmpty        (oEmpty),
        .oCount        (oCount),
        .oTx_start     (oTx_start),
        .oTx_data      (oTx_data),
        .iTx_done_tick (iTx_done_tick),
        .oBusy         (oBusy),
        .oErr          (oErr),
        .iClr_err      (iClr_err),
        .oDbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Every launch must carry the oldest accepted byte and last one cycle.
    always @(negedge clk) begin
        if (oTx_start === 1'b1) begin
            n_starts++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_unexpected: got start with data %h, expected no start", oTx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (oTx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h expected %h", oTx_data, e);
                end
            end
            n_checks++;
            if (prev_start === 1'b1) begin
                n_fail++;
                $display("FAIL start_width: got start high 2 cycles, expected 1");
            end
        end
        prev_start = oTx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        iWr = 1'b1;
        iWr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        iWr = 1'b0;
    endtask

    task automatic pulse_done();
        iTx_done_tick = 1'b1;
        tick();
        iTx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cycles(2);
        n_checks++;
        if ({oEmpty, oFull, oCount, oTx_start, oBusy, oErr} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: got e%b f%b c%0d s%b b%b err%b, expected e1 f0 c0 s0 b0 err0",
                     oEmpty, oFull, oCount, oTx_start, oBusy, oErr);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE || oTx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d data %h, expected 0 00", dbg_state, oTx_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s0;
        s0 = n_starts;
        pulse_done();
        tick();
        n_checks++;
        if (oBusy !== 1'b0 || n_starts != s0) begin
            n_fail++;
            $display("FAIL idle_done_ignored: got busy %b starts %0d, expected 0 %0d", oBusy, n_starts, s0);
        end
        write_byte(8'hA5, 1'b1);
        n_checks++;
        if (oCount !== 5'd1 || oTx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count1: got count %0d start %b, expected 1 0", oCount, oTx_start);
        end
        tick();
        n_checks++;
        if (oTx_start !== 1'b1 || oTx_data !== 8'hA5 || oCount !== 5'd0 || oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_launch: got s%b d%h c%0d b%b, expected s1 dA5 c0 b1",
                     oTx_start, oTx_data, oCount, oBusy);
        end
        wait_cycles(6);
        n_checks++;
        if (n_starts != s0 + 1 || oBusy !== 1'b1 || oTx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hold: got starts %0d busy %b data %h, expected %0d 1 A5",
                     n_starts, oBusy, oTx_data, s0 + 1);
        end
        pulse_done();
        tick();
        n_checks++;
        if (oBusy !== 1'b0 || n_starts != s0 + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_done: got busy %b starts %0d, expected 0 %0d", oBusy, n_starts, s0 + 1);
        end
    endtask

    task automatic test_burst();
        int s0;
        write_byte(8'h00, 1'b1);
        wait_cycles(2);
        for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
        n_checks++;
        if (oFull !== 1'b1 || oCount !== 5'd16) begin
            n_fail++;
            $display("FAIL burst_full: got full %b count %0d, expected 1 16", oFull, oCount);
        end
        for (int i = 0; i <= 16; i++) begin
            s0 = n_starts;
            pulse_done();
            wait_cycles(3);
            n_checks++;
            if (n_starts != s0 + ((i < 16) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL burst_one_per_done: got %0d starts after done %0d, expected %0d",
                         n_starts - s0, i, (i < 16) ? 1 : 0);
            end
        end
        n_checks++;
        if (oEmpty !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL burst_drained: got empty %b pending %0d, expected 1 0", oEmpty, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int s0;
        write_byte(8'h55, 1'b1);
        wait_cycles(2);
        for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 8'hED)), 1'b1);
        iClr_err = 1'b1;
        write_byte(8'hEE, 1'b0);
        iClr_err = 1'b0;
        n_checks++;
        if (oCount !== 5'd16 || oFull !== 1'b1 || oErr !== EXP_ERR) begin
            n_fail++;
            $display("FAIL ovf_drop: got count %0d full %b err %b, expected 16 1 %b", oCount, oFull, oErr, EXP_ERR);
        end
        pulse_done();
        write_byte(8'hEE, 1'b0);
        n_checks++;
        if (oCount !== 5'd15 || oTx_start !== 1'b1 || oErr !== EXP_ERR) begin
            n_fail++;
            $display("FAIL ovf_pop_edge: got count %0d start %b err %b, expected 15 1 %b",
                     oCount, oTx_start, oErr, EXP_ERR);
        end
        iClr_err = 1'b1;
        tick();
        iClr_err = 1'b0;
        n_checks++;
        if (oErr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got err %b expected 0", oErr);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            s0 = n_starts;
            pulse_done();
            wait_cycles(3);
            n_checks++;
            if (n_starts != s0 + ((i < 15) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL ovf_drain: got %0d starts after done %0d, expected %0d",
                         n_starts - s0, i, (i < 15) ? 1 : 0);
            end
        end
        n_checks++;
        if (oEmpty !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_drained: got empty %b pending %0d, expected 1 0", oEmpty, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int s0;
        int bad;
        bad = 0;
        write_byte(8'h3C, 1'b1);
        wait_cycles(2);
        for (int i = 0; i < 8; i++) write_byte(8'($urandom_range(0, 8'hED)), 1'b1);
        for (int i = 0; i < 40; i++) begin
            pulse_done();
            write_byte(8'($urandom_range(0, 8'hED)), 1'b1);
            if (oCount !== 5'd8 || oTx_start !== 1'b1) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_count_stable: got %0d cycles off count 8 or without start, expected 0", bad);
        end
        for (int i = 0; i < 9; i++) begin
            s0 = n_starts;
            pulse_done();
            wait_cycles(3);
            n_checks++;
            if (n_starts != s0 + ((i < 8) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL wrap_drain: got %0d starts after done %0d, expected %0d",
                         n_starts - s0, i, (i < 8) ? 1 : 0);
            end
        end
        n_checks++;
        if (oEmpty !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drained: got empty %b pending %0d, expected 1 0", oEmpty, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int s0;
        write_byte(8'h77, 1'b1);
        wait_cycles(2);
        for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 8'hED)), 1'b1);
        n_checks++;
        if (oCount !== 5'd5 || oBusy !== 1'b1 || dbg_state !== ST_BUSY) begin
            n_fail++;
            $display("FAIL midrst_setup: got count %0d busy %b state %0d, expected 5 1 2", oCount, oBusy, dbg_state);
        end
        reset_n = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        exp_q.delete();
        n_checks++;
        if ({oEmpty, oFull, oCount, oTx_start, oBusy, oErr, oTx_data} !==
            {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_flags: got e%b f%b c%0d s%b b%b err%b d%h, expected e1 f0 c0 s0 b0 err0 d00",
                     oEmpty, oFull, oCount, oTx_start, oBusy, oErr, oTx_data);
        end
        s0 = n_starts;
        pulse_done();
        wait_cycles(5);
        n_checks++;
        if (n_starts != s0 || oBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_start: got starts %0d busy %b, expected %0d 0", n_starts, oBusy, s0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
